random_walker: RTL and testbench
================================

// Module: random_walker
// PURPOSE
//  Parametrised random-walk mover for on-screen sprites (enemies, drifting logs).
//  On each timer tick it holds a direction for HOLD_TICKS ticks, then draws a new
//  direction from a random word, and steps SPEED pixels.
//  Position stays inside a configurable rectangle, either by clamp-and-stop or by
//  clamp-and-bounce. Outputs feed the object's draw block as its top-left coordinate.
// PARAMETERS
//  COORD_W     11   width of position outputs (pixels)
//  START_X     45   X loaded at reset/respawn
//  START_Y     85   Y loaded at reset/respawn
//  LIM_LEFT    45   minimum X (inclusive)
//  LIM_RIGHT   635  maximum X (inclusive)
//  LIM_UP      85   minimum Y (inclusive)
//  LIM_DOWN    400  maximum Y (inclusive)
//  SPEED       1    pixels per step, >=1
//  HOLD_TICKS  4    ticks per direction, >=1
//  BOUNCE      1    1: reverse direction on wall contact; 0: stay put, keep direction
// PORTS
//  CLK          in   1        system clock
//  RESETn       in   1        asynchronous, active-low reset
//  timer_done   in   1        1-cycle movement tick
//  enable       in   1        0: walker parked
//  freeze       in   1        1: pause; all state held
//  respawn      in   1        synchronous reload of start state
//  random       in   16       random word; [1:0] selects direction
//  ObjectStartX out  COORD_W  current X
//  ObjectStartY out  COORD_W  current Y
//  direction    out  2        0=LEFT 1=RIGHT 2=UP(Y-) 3=DOWN(Y+)
//  wall_hit     out  1        1-cycle pulse when a step was clamped
// BEHAVIOUR
//  - Reset: X=START_X, Y=START_Y, direction=0, hold_cnt=0, wall_hit=0.
//  - All outputs registered; a tick sampled at edge n is visible after edge n.
//  - Priority per edge: respawn > !enable > freeze > timer_done.
//  - respawn: identical to reset values.
//  - !enable: position and direction held; hold_cnt forced to 0, so the next
//    enabled tick picks a new direction.
//  - freeze: no state changes, hold_cnt included.
//  - Tick with enable=1, freeze=0:
//    * If hold_cnt==0: dir_eff=random[1:0] and hold_cnt<=HOLD_TICKS-1.
//    * Else: dir_eff=direction and hold_cnt<=hold_cnt-1.
//    * Step along dir_eff by SPEED. Compute in signed COORD_W+2 bits so values
//      below 0 or above the maximum never wrap.
//    * If the target lies outside [LIM_*]: clamp to the limit, wall_hit<=1.
//      If BOUNCE=1, direction<=opposite(dir_eff); otherwise direction<=dir_eff.
//    * Already at the limit, moving outward: position unchanged, wall_hit<=1,
//      same direction rule.
//  - wall_hit is 0 on every edge where the above does not fire.
//  - A new pick that points into a wall is still taken. It then clamps or bounces
//    by the rules above; there is no re-draw.
//  - Internal FSM: PARKED (!enable) / HOLD (hold_cnt>0) / PICK (hold_cnt==0).
//    * PICK->HOLD on tick.
//    * HOLD->PICK when hold_cnt reaches 0.
//    * Any state->PARKED on !enable.
//    * PARKED->PICK on enable.
//  - Elaboration error unless LIM_LEFT<=START_X<=LIM_RIGHT,
//    LIM_UP<=START_Y<=LIM_DOWN, SPEED>=1, HOLD_TICKS>=1.
// TESTING
//  1 Reset asserted, then released -> X=45, Y=85, direction=0, wall_hit=0.
//  2 random[1:0]=1, 4 ticks -> X=46,47,48,49, direction=1.
//    5th tick with random[1:0]=3 -> Y=86, X=49.
//  3 X=45, tick with random[1:0]=0, BOUNCE=1 -> X=45, wall_hit pulses, direction=1.
//    Next tick -> X=46, wall_hit=0.
//  4 SPEED=4, BOUNCE=0, X=633 moving RIGHT, tick -> X=635, wall_hit=1, direction=1.
//    Next tick -> X=635, wall_hit=1.
//  5 freeze=1 over 3 ticks -> X/Y/direction unchanged. Then respawn mid-walk
//    -> X=45, Y=85, direction=0 after one edge.
//  6 enable=0 for 2 ticks, then enable=1 with a tick and random[1:0]=2 -> Y=84 is
//    clamped to 85, wall_hit=1.
//    Also: RESETn pulsed low between edges -> outputs return to reset values at once.

Source files
------------

// File: rtl/random_walker.sv
// Random-walk sprite mover: holds a direction for HOLD_TICKS ticks, then
// redraws it and steps SPEED pixels inside a clamp/bounce rectangle.
module random_walker #(
  parameter int COORD_W    = 11,
  parameter int START_X    = 45,
  parameter int START_Y    = 85,
  parameter int LIM_LEFT   = 45,
  parameter int LIM_RIGHT  = 635,
  parameter int LIM_UP     = 85,
  parameter int LIM_DOWN   = 400,
  parameter int SPEED      = 1,
  parameter int HOLD_TICKS = 4,
  parameter int BOUNCE     = 1
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               timer_done,
  input  logic               enable,
  input  logic               freeze,
  input  logic               respawn,
  input  logic [15:0]        random,
  output logic [COORD_W-1:0] ObjectStartX,
  output logic [COORD_W-1:0] ObjectStartY,
  output logic [1:0]         direction,
  output logic               wall_hit
);

  if (START_X < LIM_LEFT || START_X > LIM_RIGHT) begin : g_bad_x
    $error("START_X outside [LIM_LEFT, LIM_RIGHT]");
  end
  if (START_Y < LIM_UP || START_Y > LIM_DOWN) begin : g_bad_y
    $error("START_Y outside [LIM_UP, LIM_DOWN]");
  end
  if (SPEED < 1) begin : g_bad_speed
    $error("SPEED must be >= 1");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("HOLD_TICKS must be >= 1");
  end

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int SW = COORD_W + 2;

  localparam logic signed [SW-1:0] SPD = SW'(SPEED);
  localparam logic signed [SW-1:0] XLO = SW'(LIM_LEFT);
  localparam logic signed [SW-1:0] XHI = SW'(LIM_RIGHT);
  localparam logic signed [SW-1:0] YLO = SW'(LIM_UP);
  localparam logic signed [SW-1:0] YHI = SW'(LIM_DOWN);

  localparam logic [COORD_W-1:0] X0 = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y0 = COORD_W'(START_Y);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    PARKED,
    HOLD,
    PICK
  } state_t;

  state_t state_q, state_d;

  logic [HW-1:0]      hold_q, hold_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [1:0]         dir_q, dir_d;
  logic               hit_q, hit_d;

  logic [1:0]         dir_eff;
  logic               horiz;
  logic               clamp_lo;
  logic               clamp_hi;
  logic signed [SW-1:0] cur, lo, hi, tgt, pos;

  // Only a HOLD state reuses the stored direction; PICK and PARKED redraw.
  assign dir_eff  = (state_q == HOLD) ? dir_q : random[1:0];
  assign horiz    = ~dir_eff[1];
  assign cur      = horiz ? signed'({2'b00, x_q})
                          : signed'({2'b00, y_q});
  assign lo       = horiz ? XLO : YLO;
  assign hi       = horiz ? XHI : YHI;
  assign tgt      = dir_eff[0] ? cur + SPD : cur - SPD;
  assign clamp_lo = tgt < lo;
  assign clamp_hi = tgt > hi;
  assign pos      = clamp_lo ? lo : (clamp_hi ? hi : tgt);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    if (respawn) begin
      state_d = PICK;
      hold_d  = '0;
      x_d     = X0;
      y_d     = Y0;
      dir_d   = 2'd0;
    end else if (!enable) begin
      state_d = PARKED;
      hold_d  = '0;
    end else if (!freeze) begin
      if (timer_done) begin
        if (state_q == HOLD) begin
          hold_d  = hold_q - HW'(1);
          state_d = (hold_q == HW'(1)) ? PICK : HOLD;
        end else begin
          hold_d  = HOLD_LAST;
          state_d = (HOLD_TICKS == 1) ? PICK : HOLD;
        end
        if (horiz) x_d = pos[COORD_W-1:0];
        else       y_d = pos[COORD_W-1:0];
        hit_d = clamp_lo | clamp_hi;
        if (hit_d && BOUNCE != 0)
          dir_d = {dir_eff[1], ~dir_eff[0]};
        else
          dir_d = dir_eff;
      end else if (state_q == PARKED) begin
        state_d = PICK;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= PICK;
      hold_q  <= '0;
      x_q     <= X0;
      y_q     <= Y0;
      dir_q   <= 2'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
    end
  end

  assign ObjectStartX = x_q;
  assign ObjectStartY = y_q;
  assign direction    = dir_q;
  assign wall_hit     = hit_q;

  logic unused_bits;
  assign unused_bits = ^{random[15:2], pos[SW-1:COORD_W]};

endmodule

// File: tb/tb_random_walker.sv
// Scoreboard bench for random_walker: two instances (bounce/speed 1 and
// stop/speed 4) driven identically and checked against a reference model.
module tb_random_walker;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b1;
  logic        timer_done = 1'b0;
  logic        enable = 1'b1;
  logic        freeze = 1'b0;
  logic        respawn = 1'b0;
  logic [15:0] random = '0;

  logic [10:0] x0, y0, x1, y1;
  logic [1:0]  d0, d1;
  logic        h0, h1;

  always #10 CLK = ~CLK;

  random_walker u0 (
    .CLK(CLK), .RESETn(RESETn), .timer_done(timer_done),
    .enable(enable), .freeze(freeze), .respawn(respawn),
    .random(random), .ObjectStartX(x0), .ObjectStartY(y0),
    .direction(d0), .wall_hit(h0)
  );

  random_walker #(.SPEED(4), .BOUNCE(0)) u1 (
    .CLK(CLK), .RESETn(RESETn), .timer_done(timer_done),
    .enable(enable), .freeze(freeze), .respawn(respawn),
    .random(random), .ObjectStartX(x1), .ObjectStartY(y1),
    .direction(d1), .wall_hit(h1)
  );

  typedef struct {
    int x; int y; int dir; int hold; int hit;
  } ms_t;

  typedef struct {
    string tag; int u; int x; int y; int dir; int hit;
  } lit_t;

  ms_t  m0, m1;
  ms_t  q0[$], q1[$];
  lit_t lq[$];
  int   total = 0;
  int   bad = 0;
  bit   done = 0;

  function automatic ms_t rst_state();
    ms_t s;
    s.x = 45; s.y = 85; s.dir = 0; s.hold = 0; s.hit = 0;
    return s;
  endfunction

  function automatic int opp(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  // Reference walker: positions as plain integers, limits from the rectangle.
  function automatic ms_t mstep(ms_t s, bit rst, bit rsp, bit en,
                                bit frz, bit tk, int rnd,
                                int spd, bit bnc);
    ms_t n;
    int d, p, lo, hi;
    n = s;
    n.hit = 0;
    if (!rst || rsp) begin
      n = rst_state();
    end else if (!en) begin
      n.hold = 0;
    end else if (!frz && tk) begin
      d = (s.hold == 0) ? (rnd & 3) : s.dir;
      n.hold = (s.hold == 0) ? 4 - 1 : s.hold - 1;
      lo = (d < 2) ? 45 : 85;
      hi = (d < 2) ? 635 : 400;
      p = (d < 2) ? s.x : s.y;
      p = (d == 1 || d == 3) ? p + spd : p - spd;
      n.dir = d;
      if (p < lo || p > hi) begin
        p = (p < lo) ? lo : hi;
        n.hit = 1;
        if (bnc) n.dir = opp(d);
      end
      if (d < 2) n.x = p;
      else n.y = p;
    end
    return n;
  endfunction

  task automatic cmp(string tag, int u, int ex, int ey, int ed, int eh);
    int ax, ay, ad, ah;
    ax = u ? int'(x1) : int'(x0);
    ay = u ? int'(y1) : int'(y0);
    ad = u ? int'(d1) : int'(d0);
    ah = u ? int'(h1) : int'(h0);
    total++;
    if ((ex >= 0 && ax != ex) || (ey >= 0 && ay != ey) ||
        (ed >= 0 && ad != ed) || (eh >= 0 && ah != eh)) begin
      bad++;
      $display("FAIL %s u%0d: got x=%0d y=%0d dir=%0d hit=%0d want x=%0d y=%0d dir=%0d hit=%0d",
               tag, u, ax, ay, ad, ah, ex, ey, ed, eh);
    end
  endtask

  task automatic do_cycle(bit rst, bit rsp, bit en, bit frz, bit tk, int rnd);
    @(negedge CLK);
    RESETn     = rst;
    respawn    = rsp;
    enable     = en;
    freeze     = frz;
    timer_done = tk;
    random     = rnd[15:0];
    m0 = mstep(m0, rst, rsp, en, frz, tk, rnd, 1, 1'b1);
    m1 = mstep(m1, rst, rsp, en, frz, tk, rnd, 4, 1'b0);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic lit(string tag, int u, int x, int y, int dir, int hit);
    lit_t l;
    l.tag = tag; l.u = u; l.x = x; l.y = y; l.dir = dir; l.hit = hit;
    lq.push_back(l);
  endtask

  initial begin : monitor
    bit   pre;
    ms_t  e;
    lit_t l;
    forever begin
      pre = RESETn;
      @(posedge CLK or negedge RESETn);
      #1;
      if (pre && !RESETn) begin
        cmp("async_rst", 0, 45, 85, 0, 0);
        cmp("async_rst", 1, 45, 85, 0, 0);
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          cmp("sb", 0, e.x, e.y, e.dir, e.hit);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          cmp("sb", 1, e.x, e.y, e.dir, e.hit);
        end
        while (lq.size() > 0) begin
          l = lq.pop_front();
          cmp(l.tag, l.u, l.x, l.y, l.dir, l.hit);
        end
        if (done) begin
          total++;
          if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending want 0",
                     q0.size(), q1.size());
          end
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "timeout");
  end

  initial begin : stim
    m0 = rst_state();
    m1 = rst_state();

    do_cycle(0, 0, 1, 0, 0, 0);
    do_cycle(0, 0, 1, 0, 0, 0);
    do_cycle(1, 0, 1, 0, 0, 0);
    lit("reset", 0, 45, 85, 0, 0);

    repeat (4) begin
      do_cycle(1, 0, 1, 0, 1, 1);
      do_cycle(1, 0, 1, 0, 0, int'($urandom));
    end
    lit("walk_right", 0, 49, 85, 1, 0);
    do_cycle(1, 0, 1, 0, 1, 3);
    lit("turn_down", 0, 49, 86, 3, 0);

    do_cycle(1, 1, 1, 0, 0, 0);
    do_cycle(1, 0, 1, 0, 1, 0);
    lit("bounce_left", 0, 45, 85, 1, 1);
    do_cycle(1, 0, 1, 0, 1, 0);
    lit("after_bounce", 0, 46, 85, 1, 0);

    repeat (3) do_cycle(1, 0, 1, 1, 1, int'($urandom));
    lit("freeze", 0, 46, 85, 1, 0);
    do_cycle(1, 1, 1, 0, 1, 2);
    lit("respawn", 0, 45, 85, 0, 0);

    repeat (2) do_cycle(1, 0, 0, 0, 1, int'($urandom));
    do_cycle(1, 0, 1, 0, 1, 2);
    lit("park_pick_up", 0, 45, 85, 3, 1);
    lit("park_pick_up_stop", 1, 45, 85, 2, 1);

    do_cycle(1, 1, 1, 0, 0, 0);
    repeat (147) do_cycle(1, 0, 1, 0, 1, 1);
    lit("speed4_633", 1, 633, 85, 1, 0);
    do_cycle(1, 0, 1, 0, 1, 1);
    lit("speed4_clamp", 1, 635, 85, 1, 1);
    do_cycle(1, 0, 1, 0, 1, 1);
    lit("speed4_stuck", 1, 635, 85, 1, 1);
    lit("speed1_far", 0, 194, 85, 1, 0);

    @(posedge CLK);
    #3 RESETn = 1'b0;
    #3 RESETn = 1'b1;
    m0 = rst_state();
    m1 = rst_state();

    for (int i = 0; i < 500; i++) begin
      do_cycle(1,
               $urandom_range(0, 49) == 0,
               $urandom_range(0, 19) != 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 1) == 1,
               int'($urandom));
    end
    do_cycle(1, 0, 1, 0, 0, 0);
    done = 1'b1;
  end

endmodule
